// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if : byte-stream / instruction-memory bus for prog_loader (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface prog_loader_if #(
  parameter int N = 16
);
  logic         start;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_din;
  logic         mem_wen;
  logic         busy;
  logic         done;
  logic         error;
  logic [N-1:0] word_count;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_addr, mem_din, mem_wen, busy, done, error, word_count
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_addr, mem_din, mem_wen, busy, done, error, word_count
  );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader : assembles a big-endian byte stream into instruction words (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module prog_loader #(
  parameter int N     = 16,
  parameter int BASE  = 0,
  parameter int DEPTH = 4096
) (
  input  logic clk,
  input  logic rst,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DAT_HI = 3'd3,
    S_DAT_LO = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  // Widened by one bit so DEPTH = 65536 would still compare correctly.
  localparam logic [16:0]  DEPTH_W = 17'(DEPTH);
  localparam logic [N-1:0] BASE_W  = N'(BASE);

  state_e       state_q, state_d;
  logic [15:0]  len_q, len_d;
  logic [7:0]   hi_q, hi_d;
  logic [N-1:0] addr_q, addr_d;
  logic [N-1:0] wcnt_q, wcnt_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0] mem_din_q, mem_din_d;
  logic         in_ready_w;
  logic         accept_w;

  assign accept_w = bus.in_valid && in_ready_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      wcnt_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      wcnt_q     <= wcnt_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    wcnt_d      = wcnt_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    in_ready_w  = 1'b0;
    bus.mem_wen = 1'b0;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    bus.error   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        bus.busy  = 1'b0;
        bus.done  = (state_q == S_DONE);
        bus.error = (state_q == S_ERROR);
        if (bus.start) begin
          state_d = S_LEN_HI;
          wcnt_d  = '0;
          addr_d  = BASE_W;
        end
      end
      S_LEN_HI: begin
        in_ready_w = 1'b1;
        if (accept_w) begin
          len_d   = {bus.in_data, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        in_ready_w = 1'b1;
        if (accept_w) begin
          len_d = {len_q[15:8], bus.in_data};
          if (len_d == 16'd0)
            state_d = S_DONE;
          else if ({1'b0, len_d} > DEPTH_W)
            state_d = S_ERROR;
          else
            state_d = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        in_ready_w = 1'b1;
        if (accept_w) begin
          hi_d    = bus.in_data;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        in_ready_w = 1'b1;
        if (accept_w) begin
          // Capture the write beat now so mem_addr/mem_din hold outside WRITE.
          mem_din_d  = {hi_q, bus.in_data};
          mem_addr_d = addr_q;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        bus.mem_wen = 1'b1;
        wcnt_d      = wcnt_q + 1'b1;
        addr_d      = addr_q + 1'b1;
        state_d     = (wcnt_d == len_q) ? S_DONE : S_DAT_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.word_count = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader : randomized self-checking bench for prog_loader (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

  localparam int N     = 16;
  localparam int BASE  = 0;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] wq[$];
  logic        prev_wen;

  prog_loader_if #(.N(N)) bus ();

  prog_loader #(.N(N), .BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: record every write beat; a beat must be one cycle wide.
  always @(negedge clk) begin
    if (bus.mem_wen) begin
      wq.push_back({bus.mem_addr, bus.mem_din});
      chk("wen_one_cycle", {31'd0, prev_wen}, 32'd0);
      chk("wen_not_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    prev_wen <= bus.mem_wen;
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send(input logic [7:0] s[$], input bit gaps, input int poke);
    int idx;
    int budget;
    bit acc;
    bit poked;
    idx = 0; budget = 0; poked = 0;
    while (idx < s.size()) begin
      bus.in_data  = s[idx];
      bus.in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (idx == poke && !poked) begin
        bus.start = 1'b1;
        poked = 1;
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (acc) idx++;
      budget++;
      if (budget > 300) begin
        chk("stream_timeout", idx, s.size());
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // Reference: a load of L words either errors (L > DEPTH), finishes empty,
  // or writes word i to BASE+i.
  task automatic run_load(input logic [15:0] len, input logic [15:0] w[$],
                          input bit gaps, input int poke);
    logic [7:0] s[$];
    int exp_n;
    bit exp_err;
    s = {len[15:8], len[7:0]};
    foreach (w[i]) begin
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
    end
    exp_err = (int'(len) > DEPTH);
    exp_n   = exp_err ? 0 : int'(len);
    wq.delete();
    pulse_start();
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    send(s, gaps, poke);
    if (len == 16'd0 || exp_err) begin
      @(negedge clk);
      chk("early_done", {31'd0, bus.done}, {31'd0, !exp_err});
      chk("early_error", {31'd0, bus.error}, {31'd0, exp_err});
    end
    for (int c = 0; c < 10 && bus.busy; c++) @(negedge clk);
    @(negedge clk);
    chk("busy_end", {31'd0, bus.busy}, 32'd0);
    chk("done", {31'd0, bus.done}, {31'd0, !exp_err});
    chk("error", {31'd0, bus.error}, {31'd0, exp_err});
    chk("word_count", {16'd0, bus.word_count}, exp_n);
    chk("in_ready_idle", {31'd0, bus.in_ready}, 32'd0);
    chk("n_writes", wq.size(), exp_n);
    for (int i = 0; i < exp_n && i < wq.size(); i++) begin
      chk("waddr", {16'd0, wq[i][31:16]}, BASE + i);
      chk("wdata", {16'd0, wq[i][15:0]}, {16'd0, w[i]});
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_mid();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_wen", {31'd0, bus.mem_wen}, 32'd0);
    chk("rst_addr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_din", {16'd0, bus.mem_din}, 32'd0);
    chk("rst_wcount", {16'd0, bus.word_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w[$];
    logic [7:0]  s[$];
    logic [15:0] len;
    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.in_data = 8'h00; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("init_busy", {31'd0, bus.busy}, 32'd0);
    chk("init_done", {31'd0, bus.done}, 32'd0);
    chk("init_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("init_wcount", {16'd0, bus.word_count}, 32'd0);
    @(posedge clk); #1;

    // Basic, gapped, and start-ignored-while-busy loads.
    w = {16'h1234, 16'hABCD};
    run_load(16'd2, w, 1'b0, -1);
    run_load(16'd2, w, 1'b1, -1);
    run_load(16'd2, w, 1'b0, 3);

    w.delete();
    run_load(16'd0, w, 1'b0, -1);
    run_load(16'd5, w, 1'b0, -1);
    w = {16'hBEEF};
    run_load(16'd1, w, 1'b0, -1);

    rst_mid();

    // Abort after the first word, then reload from scratch.
    wq.delete();
    pulse_start();
    s = {8'h00, 8'h02, 8'h12, 8'h34};
    send(s, 1'b0, -1);
    for (int c = 0; c < 20 && !bus.mem_wen; c++) @(negedge clk);
    chk("abort_wen_seen", {31'd0, bus.mem_wen}, 32'd1);
    rst_mid();
    w = {16'h55AA};
    run_load(16'd1, w, 1'b0, -1);

    for (int it = 0; it < 12; it++) begin
      len = 16'($urandom_range(0, DEPTH + 2));
      if ($urandom_range(0, 4) == 0) len = 16'($urandom_range(DEPTH + 1, 65535));
      w.delete();
      if (int'(len) <= DEPTH)
        for (int k = 0; k < int'(len); k++) w.push_back(16'($urandom));
      run_load(len, w, ($urandom_range(0, 1) == 1), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
